// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared constants and types for the four-channel servo PWM generator.
//   FULL_CYCLE is the frame length in clocks. COUNTER_BIT_WIDTH is the width of
//   the frame counter. width_t and count_t are deliberately the same width, so
//   the compare in each channel needs no extension.
package servo_pkg;

    localparam int SIGNAL_BIT_WIDTH  = 15;
    localparam int ADDRESS_BIT_WIDTH = 2;
    localparam int PWM_SIGNAL_COUNT  = 2 ** ADDRESS_BIT_WIDTH;
    localparam int FULL_CYCLE        = 20000;
    localparam int COUNTER_BIT_WIDTH = $clog2(FULL_CYCLE);

    typedef logic [SIGNAL_BIT_WIDTH-1:0]  width_t;
    typedef logic [COUNTER_BIT_WIDTH-1:0] count_t;
    typedef logic [ADDRESS_BIT_WIDTH-1:0] addr_t;

    // Last counter value of a frame. The edge leaving this value is the frame boundary.
    localparam count_t LAST_COUNT = count_t'(FULL_CYCLE - 1);

endpackage

// File: rtl/servo_if.sv
// servo_if
//   Host write port of the servo controller.
//   cs   : write strobe, sampled on the rising clock
//   addr : channel to write
//   data : pulse width in clocks
//   The master modport is used by the host. The slave modport is used by servo_controller.
interface servo_if;
    import servo_pkg::*;

    logic   cs;
    addr_t  addr;
    width_t data;

    modport master (output cs, addr, data);
    modport slave  (input  cs, addr, data);

endinterface

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel
//   One PWM output with a double-buffered pulse width.
//   clk, rst     : clock and asynchronous active-low reset
//   write_en     : load data into the pending width this cycle
//   data         : new pulse width in clocks
//   boundary     : high during the last cycle of a frame. On the following edge,
//                  pending is copied into active.
//   counter_next : value the shared frame counter takes on the coming edge
//   pwm          : registered PWM output
module servo_pwm_channel
    import servo_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   write_en,
    input  width_t data,
    input  logic   boundary,
    input  count_t counter_next,
    output logic   pwm
);

    width_t pending;
    width_t active;
    width_t active_next;

    // The active width changes only at a frame boundary. A write on the
    // boundary edge therefore reaches pending only, and the frame that is just
    // starting keeps the old pending value.
    always_comb begin
        active_next = boundary ? pending : active;
    end

    // The output is compared against the values that counter and active take
    // after this edge. This makes the registered output line up with the
    // counter: counts 0..C-1 are high, giving exactly C clocks. A width of
    // FULL_CYCLE or more is never reached by the counter, so the output stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            active  <= '0;
            pwm     <= 1'b0;
        end else begin
            if (write_en) begin
                pending <= data;
            end
            active <= active_next;
            pwm    <= (counter_next < active_next);
        end
    end

endmodule

// File: rtl/servo_controller.sv
// servo_controller
//   Four-channel hobby-servo PWM generator. All channels share one frame of
//   FULL_CYCLE clocks. Widths written by the host take effect at the next frame boundary.
//   clk    : sole clock, rising edge
//   rst    : asynchronous active-low reset. It clears all widths and the outputs.
//   bus    : host write port (servo_if.slave)
//   signal : PWM outputs, bit i = channel i
module servo_controller
    import servo_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    servo_if.slave                      bus,
    output logic [PWM_SIGNAL_COUNT-1:0] signal
);

    count_t                      counter;
    count_t                      counter_next;
    logic                        boundary;
    logic [PWM_SIGNAL_COUNT-1:0] write_en;

    // The boundary is the last count of the frame. On that edge the counter
    // wraps to 0, and every channel loads its pending width.
    always_comb begin
        boundary     = (counter == LAST_COUNT);
        counter_next = boundary ? '0 : counter + count_t'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
        end else begin
            counter <= counter_next;
        end
    end

    // One-hot write enable from the channel address.
    always_comb begin
        write_en = '0;
        if (bus.cs) begin
            write_en[bus.addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < PWM_SIGNAL_COUNT; i++) begin : g_channel
        servo_pwm_channel u_channel (
            .clk          (clk),
            .rst          (rst),
            .write_en     (write_en[i]),
            .data         (bus.data),
            .boundary     (boundary),
            .counter_next (counter_next),
            .pwm          (signal[i])
        );
    end

endmodule

// File: tb/tb_servo_controller.sv
// tb_servo_controller
//   Self-checking bench for servo_controller.
//   The bench counts edges since reset release (cyc). The frame counter value
//   after each edge is cyc % FULL_CYCLE, and the vector offsets below are those
//   counter values. Outputs are sampled 1 time unit after each rising edge.
//   Table rows for a frame window are pushed onto a scoreboard queue. They are
//   then popped and compared when the run reaches each row's offset.
module tb_servo_controller;
    import servo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] signal;

    servo_if bus ();

    servo_controller dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .signal (signal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         frame;
        int         offset;
        logic [3:0] mask;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cur_cnt[4];
    int last_cnt[4];
    bit noise  = 1'b0;

    function automatic vec_t row(int frame, int offset, logic [3:0] mask, logic [3:0] exp);
        vec_t v;
        v.frame  = frame;
        v.offset = offset;
        v.mask   = mask;
        v.exp    = exp;
        return v;
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            cur_cnt[i]  = 0;
            last_cnt[i] = 0;
        end
    endtask

    // Advance one clock, sample after the edge, and keep per-frame high counts.
    // When noise is set, addr and data are scrambled while cs stays low.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % FULL_CYCLE == 0) begin
            last_cnt = cur_cnt;
            for (int i = 0; i < 4; i++) cur_cnt[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (signal[i] === 1'b1) cur_cnt[i]++;
        end
        if (noise && !bus.cs) begin
            bus.addr = 2'($urandom_range(0, 3));
            bus.data = 15'($urandom_range(0, 32767));
        end
    endtask

    task automatic goto(int pos);
        int guard = 0;
        while ((cyc % FULL_CYCLE) != pos && guard < 2 * FULL_CYCLE) begin
            tick();
            guard++;
        end
        if ((cyc % FULL_CYCLE) != pos) begin
            checks++;
            errors++;
            $display("[TB] FAIL goto: reached count %0d, required %0d", cyc % FULL_CYCLE, pos);
        end
    endtask

    task automatic write_ch(int ch, int val);
        bus.cs   = 1'b1;
        bus.addr = 2'(ch);
        bus.data = 15'(val);
        tick();
        bus.cs   = 1'b0;
    endtask

    task automatic check_output(string name, logic [3:0] actual, logic [3:0] mask, logic [3:0] expected);
        checks++;
        if ((actual & mask) !== (expected & mask)) begin
            errors++;
            $display("[TB] FAIL %s: signal=%b required=%b (mask %b)", name, actual, expected, mask);
        end
    endtask

    task automatic check_count(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic check_frame_counts(string tag, int e0, int e1, int e2, int e3);
        check_count({tag, " ch0 high clocks"}, last_cnt[0], e0);
        check_count({tag, " ch1 high clocks"}, last_cnt[1], e1);
        check_count({tag, " ch2 high clocks"}, last_cnt[2], e2);
        check_count({tag, " ch3 high clocks"}, last_cnt[3], e3);
    endtask

    // Push the table rows of one frame window onto the scoreboard, then pop and
    // compare each row as the run reaches its offset.
    task automatic apply_stimulus(int frame, int lo, int hi);
        vec_t v;
        foreach (vecs[i]) begin
            if (vecs[i].frame == frame && vecs[i].offset >= lo && vecs[i].offset <= hi) begin
                sb.push_back(vecs[i]);
            end
        end
        while (sb.size() > 0) begin
            v = sb.pop_front();
            goto(v.offset);
            check_output($sformatf("frame%0d@%0d", v.frame, v.offset), signal, v.mask, v.exp);
        end
    endtask

    initial begin
        #(2_000_000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Expected outputs per frame, given as bit 3 .. bit 0.
        vecs.push_back(row(0, 2,     4'b1111, 4'b0000));
        // Frame 1: ch0=1000 is active. The 1500 writes made at 600 must not apply yet.
        vecs.push_back(row(1, 500,   4'b0011, 4'b0001));
        vecs.push_back(row(1, 999,   4'b0011, 4'b0001));
        vecs.push_back(row(1, 1000,  4'b0011, 4'b0000));
        vecs.push_back(row(1, 1005,  4'b0011, 4'b0000));
        vecs.push_back(row(1, 1505,  4'b0011, 4'b0000));
        // Frame 2: ch0=ch1=1500, ch2=0, ch3=20000.
        vecs.push_back(row(2, 0,     4'b1111, 4'b1011));
        vecs.push_back(row(2, 500,   4'b1111, 4'b1011));
        vecs.push_back(row(2, 1000,  4'b1111, 4'b1011));
        vecs.push_back(row(2, 1400,  4'b1111, 4'b1011));
        vecs.push_back(row(2, 1499,  4'b1111, 4'b1011));
        vecs.push_back(row(2, 1500,  4'b1111, 4'b1000));
        vecs.push_back(row(2, 1600,  4'b1111, 4'b1000));
        vecs.push_back(row(2, 19999, 4'b1111, 4'b1000));
        // Frame 3: 500/1000/1500/2000. ch0 ignores the value written on the boundary edge.
        vecs.push_back(row(3, 0,     4'b1111, 4'b1111));
        vecs.push_back(row(3, 250,   4'b1111, 4'b1111));
        vecs.push_back(row(3, 499,   4'b1111, 4'b1111));
        vecs.push_back(row(3, 500,   4'b1111, 4'b1110));
        vecs.push_back(row(3, 999,   4'b1111, 4'b1110));
        vecs.push_back(row(3, 1000,  4'b1111, 4'b1100));
        vecs.push_back(row(3, 1500,  4'b1111, 4'b1000));
        vecs.push_back(row(3, 1999,  4'b1111, 4'b1000));
        vecs.push_back(row(3, 2000,  4'b1111, 4'b0000));
        vecs.push_back(row(3, 2500,  4'b1111, 4'b0000));
        // Frame 4: ch0=1 (the boundary-edge write), ch1=1000, ch2=1500, ch3=32767.
        vecs.push_back(row(4, 0,     4'b1111, 4'b1111));
        vecs.push_back(row(4, 1,     4'b1111, 4'b1110));
        vecs.push_back(row(4, 999,   4'b1111, 4'b1110));
        vecs.push_back(row(4, 1000,  4'b1111, 4'b1100));
        vecs.push_back(row(4, 1200,  4'b1111, 4'b1100));

        bus.cs   = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        rst      = 1'b0;
        clear_counts();

        #22;
        check_output("reset state", signal, 4'b1111, 4'b0000);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cyc = 0;
        clear_counts();

        // Frame 0: nothing is active yet.
        apply_stimulus(0, 0, 100);
        goto(10);
        write_ch(0, 1000);
        goto(0);
        check_frame_counts("frame0", 0, 0, 0, 0);

        // Frame 1
        apply_stimulus(1, 0, 599);
        goto(600);
        write_ch(0, 1500);
        write_ch(1, 1500);
        apply_stimulus(1, 600, 1999);
        goto(2000);
        write_ch(2, 0);
        write_ch(3, 20000);
        noise = 1'b1;
        goto(0);
        check_frame_counts("frame1", 1000, 0, 0, 0);

        // Frame 2: while cs is low, addr and data are scrambled.
        apply_stimulus(2, 0, 2999);
        goto(3000);
        write_ch(0, 500);
        write_ch(1, 1000);
        write_ch(2, 1500);
        write_ch(3, 2000);
        apply_stimulus(2, 3000, 19999);
        // This write lands exactly on the boundary edge.
        write_ch(0, 1);
        noise = 1'b0;
        check_frame_counts("frame2", 1500, 1500, 0, 20000);

        // Frame 3
        apply_stimulus(3, 0, 2999);
        goto(3000);
        write_ch(3, 32767);
        goto(0);
        check_frame_counts("frame3", 500, 1000, 1500, 2000);

        // Frame 4, up to count 1200: the width-1 pulse lasts exactly one clock.
        apply_stimulus(4, 0, 19999);
        check_count("frame4 ch0 width-1 pulse", cur_cnt[0], 1);
        check_count("frame4 ch1 partial", cur_cnt[1], 1000);
        check_count("frame4 ch3 partial", cur_cnt[3], 1201);

        // Reset while ch2 and ch3 are high. The outputs must drop before any clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_output("async reset drop", signal, 4'b1111, 4'b0000);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        cyc = 0;
        clear_counts();
        goto(1500);
        check_output("post-reset low", signal, 4'b1111, 4'b0000);
        check_count("post-reset high clocks",
                    cur_cnt[0] + cur_cnt[1] + cur_cnt[2] + cur_cnt[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
